// File: rtl/mc_req_master_pkg.sv
// Shared types and constants for the mc_req_master memory-controller initiator.
package mc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;

    localparam logic W_R_WRITE = 1'b1;
    localparam logic W_R_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mc_mst_state_e;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mc_cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mc_req_master_if.sv
// Command, response and slave-side bus of mc_req_master; master is the initiator's view.
interface mc_req_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_wr;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  en;
    logic                  w_r;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  slv_error;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, data_out, slv_error,
        output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, en, w_r, wr_addr, in_data
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, data_out, slv_error,
        input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, en, w_r, wr_addr, in_data
    );

endinterface

// File: rtl/mc_req_master_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module mc_cmd_fifo
    import mc_pkg::*;
#(
    parameter type T     = mc_cmd_t,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  T               wdata,
    output T               rdata,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mc_req_master.sv
// Memory-controller initiator: buffers commands, issues one en pulse each, returns one response each.
// Optional MC_REQ_MASTER_STATS_EN adds saturating write/read/error response counters.
module mc_req_master
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH = mc_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mc_pkg::ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int CMD_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MC_REQ_MASTER_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_err_cnt,
`endif
    mc_req_master_if.master bus
);

    localparam int CNT_W = 4;
    localparam int CW    = $clog2(CMD_DEPTH) + 1;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t          fifo_wdata, fifo_rdata;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    mc_mst_state_e         state_q, state_d;
    logic                  txn_wr_q, txn_wr_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  en_q, en_d;
    logic                  w_r_q, w_r_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_wr_q, rsp_wr_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_hs;

    assign rsp_hs     = rsp_valid_q && bus.rsp_ready;
    assign fifo_wdata = '{wr: bus.cmd_wr, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    mc_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        txn_wr_d    = txn_wr_q;
        wait_cnt_d  = wait_cnt_q;
        en_d        = 1'b0;
        w_r_d       = 1'b0;
        wr_addr_d   = '0;
        in_data_d   = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        fifo_push   = bus.cmd_valid && cmd_ready_q && !fifo_full;

        unique case (state_q)
            IDLE: begin
                // Bus fields are loaded here so they appear together with en in ISSUE.
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    txn_wr_d  = fifo_rdata.wr;
                    en_d      = 1'b1;
                    w_r_d     = fifo_rdata.wr ? W_R_WRITE : W_R_READ;
                    wr_addr_d = fifo_rdata.addr;
                    in_data_d = fifo_rdata.wdata;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = CNT_W'(RD_LATENCY);
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - CNT_W'(1);
                if (wait_cnt_q == CNT_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = txn_wr_q;
                    rsp_rdata_d = txn_wr_q ? '0 : bus.data_out;
                    rsp_err_d   = bus.slv_error;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    rsp_wr_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (fifo_count + CW'(fifo_push) - CW'(fifo_pop)) != CW'(CMD_DEPTH);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            txn_wr_q    <= 1'b0;
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            en_q        <= 1'b0;
            w_r_q       <= 1'b0;
            wr_addr_q   <= '0;
            in_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            txn_wr_q    <= txn_wr_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            en_q        <= en_d;
            w_r_q       <= w_r_d;
            wr_addr_q   <= wr_addr_d;
            in_data_q   <= in_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.en        = en_q;
    assign bus.w_r       = w_r_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.in_data   = in_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_wr    = rsp_wr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef MC_REQ_MASTER_STATS_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_rd_q, stat_rd_d;
    logic [15:0] stat_err_q, stat_err_d;

    // Clear takes priority over a handshake in the same cycle.
    always_comb begin
        stat_wr_d  = stat_wr_q;
        stat_rd_d  = stat_rd_q;
        stat_err_d = stat_err_q;
        if (stat_clr) begin
            stat_wr_d  = '0;
            stat_rd_d  = '0;
            stat_err_d = '0;
        end else if (rsp_hs) begin
            if (rsp_wr_q) stat_wr_d = sat_inc16(stat_wr_q);
            else          stat_rd_d = sat_inc16(stat_rd_q);
            if (rsp_err_q) stat_err_d = sat_inc16(stat_err_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_wr_q  <= '0;
            stat_rd_q  <= '0;
            stat_err_q <= '0;
        end else begin
            stat_wr_q  <= stat_wr_d;
            stat_rd_q  <= stat_rd_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_wr_cnt  = stat_wr_q;
    assign stat_rd_cnt  = stat_rd_q;
    assign stat_err_cnt = stat_err_q;
`else
    // Without the counters the response path is identical; rsp_hs only feeds the FSM.
`endif

endmodule

// File: tb/tb_mc_req_master.sv
// Scoreboard bench for mc_req_master: two instances (RD_LATENCY 1 and 3) share stimulus via sel.
module tb_mc_req_master;
    import mc_pkg::*;

    localparam int DW = 32, AW = 8, LAT_A = 1, LAT_B = 3, DEPTH = 4;
    localparam logic [31:0] FILL [6] = '{32'hC0DE_0030, 32'hC0DE_0031, 32'hC0DE_0032,
                                         32'hC0DE_0033, 32'hC0DE_0034, 32'h0000_0000};

    typedef struct {
        logic          wr;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b1, sel = 1'b0;
    logic cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0, slv_error = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0, data_out = '0;

    int   n_checks = 0, n_errors = 0;
    exp_t exp_q[$];
    int   en_cycles[$];
    logic wr_log[$];

    mc_req_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    mc_req_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

`ifdef MC_REQ_MASTER_STATS_EN
    logic stat_clr = 1'b0;
    logic [15:0] stat_wr_a, stat_rd_a, stat_err_a, stat_wr_b, stat_rd_b, stat_err_b;
`endif

    mc_req_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT_A), .CMD_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .reset(rst_n),
`ifdef MC_REQ_MASTER_STATS_EN
        .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_a), .stat_rd_cnt(stat_rd_a), .stat_err_cnt(stat_err_a),
`endif
        .bus(bus_a)
    );

    mc_req_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT_B), .CMD_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .reset(rst_n),
`ifdef MC_REQ_MASTER_STATS_EN
        .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_b), .stat_rd_cnt(stat_rd_b), .stat_err_cnt(stat_err_b),
`endif
        .bus(bus_b)
    );

    assign bus_a.cmd_valid = cmd_valid && !sel;
    assign bus_b.cmd_valid = cmd_valid && sel;
    assign bus_a.cmd_wr    = cmd_wr;     assign bus_b.cmd_wr    = cmd_wr;
    assign bus_a.cmd_addr  = cmd_addr;   assign bus_b.cmd_addr  = cmd_addr;
    assign bus_a.cmd_wdata = cmd_wdata;  assign bus_b.cmd_wdata = cmd_wdata;
    assign bus_a.rsp_ready = rsp_ready;  assign bus_b.rsp_ready = rsp_ready;
    assign bus_a.data_out  = data_out;   assign bus_b.data_out  = data_out;
    assign bus_a.slv_error = slv_error;  assign bus_b.slv_error = slv_error;

    logic          cmd_ready_m, rsp_valid_m, rsp_wr_m, rsp_err_m, en_m, w_r_m;
    logic [DW-1:0] rsp_rdata_m, in_data_m;
    logic [AW-1:0] addr_m;
    assign cmd_ready_m = sel ? bus_b.cmd_ready : bus_a.cmd_ready;
    assign rsp_valid_m = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign rsp_wr_m    = sel ? bus_b.rsp_wr    : bus_a.rsp_wr;
    assign rsp_rdata_m = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign rsp_err_m   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
    assign en_m        = sel ? bus_b.en        : bus_a.en;
    assign w_r_m       = sel ? bus_b.w_r       : bus_a.w_r;
    assign addr_m      = sel ? bus_b.wr_addr   : bus_a.wr_addr;
    assign in_data_m   = sel ? bus_b.in_data   : bus_a.in_data;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: valid read data and error only in cycle T+latency, garbage in every other cycle.
    logic [DW-1:0] mem [256];
    int            cyc = 0, pend_cnt = 0;
    logic          pend_wr = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend_cnt = 0;
        end else if (en_m) begin
            en_cycles.push_back(cyc);
            wr_log.push_back(w_r_m);
            if (w_r_m) mem[addr_m] = in_data_m;
            pend_wr   = w_r_m;
            pend_addr = addr_m;
            pend_cnt  = sel ? LAT_B : LAT_A;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
        end
    end

    always @(negedge clk) begin
        if (pend_cnt == 1) begin
            data_out  = pend_wr ? $urandom : mem[pend_addr];
            slv_error = !pend_wr && (pend_addr == 8'hFF);
        end else begin
            data_out  = $urandom;
            slv_error = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every response handshake and checks idle bus values.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid_m && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid_m, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_wr", rsp_wr_m, e.wr);
                check("rsp_rdata", rsp_rdata_m, e.rdata);
                check("rsp_err", rsp_err_m, e.err);
            end
        end
        if (!en_m) check("bus_idle_zero", {w_r_m, addr_m, in_data_m}, '0);
        if (en_m) check("en_single_pulse", prev_en, 1'b0);
        prev_en = en_m;
    end

    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rdata, input logic exp_err, input int budget,
                        output bit accepted);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        accepted  = 1'b0;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready_m) begin
                accepted = 1'b1;
                e = '{wr: wr, rdata: exp_rdata, err: exp_err};
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_ok(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] exp_rdata, input logic exp_err);
        bit acc;
        send(wr, addr, wdata, exp_rdata, exp_err, 50, acc);
        check("cmd_accept", acc, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int n_acc, base;

        #1 rst_n = 1'b0;
        #6;
        check("reset_ctrl", {cmd_ready_m, rsp_valid_m, en_m, w_r_m, rsp_wr_m, rsp_err_m}, '0);
        check("reset_addr", addr_m, '0);
        check("reset_data", {in_data_m, rsp_rdata_m}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", cmd_ready_m, 1'b1);

        // Write then read at latency 1; back-to-back commands issue one transaction per 4 cycles.
        rsp_ready = 1'b1;
        base = en_cycles.size();
        send_ok(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        send_ok(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        drain("wr_rd_drain");
        check("wr_rd_en_count", en_cycles.size() - base, 2);
        check("wr_rd_w_r_seq", {wr_log[base], wr_log[base+1]}, 2'b10);
        check("lat1_throughput", en_cycles[base+1] - en_cycles[base], LAT_A + 3);

        // Latency 3 instance: read data valid only in cycle T+3.
        sel = 1'b1;
        base = en_cycles.size();
        send_ok(1'b1, 8'h20, 32'h0000_1234, 32'h0, 1'b0);
        send_ok(1'b0, 8'h20, 32'h0, 32'h0000_1234, 1'b0);
        drain("lat3_drain");
        check("lat3_throughput", en_cycles[base+1] - en_cycles[base], LAT_B + 3);
        sel = 1'b0;

        // FIFO full: with responses stalled only 4 queued + 1 in flight are accepted.
        for (int i = 0; i < 5; i++) send_ok(1'b1, 8'(8'h30 + i), FILL[i], 32'h0, 1'b0);
        drain("fill_drain");
        rsp_ready = 1'b0;
        base  = en_cycles.size();
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 8'(8'h30 + i), 32'h0, FILL[i], 1'b0, 20, acc);
            n_acc += int'(acc);
        end
        check("full_accepted", n_acc, 5);
        check("full_en_stalled", en_cycles.size() - base, 1);
        @(negedge clk);
        check("full_cmd_ready_low", cmd_ready_m, 1'b0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain("full_drain");
        check("full_en_total", en_cycles.size() - base, 5);

        // Slave error only on the read to 8'hFF; the following read is clean.
        send_ok(1'b1, 8'hFF, 32'h5A5A5A5A, 32'h0, 1'b0);
        send_ok(1'b0, 8'hFF, 32'h0, 32'h5A5A5A5A, 1'b1);
        send_ok(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        drain("err_drain");

        // Reset while the first of three reads waits for data; two remain queued.
        base = en_cycles.size();
        send_ok(1'b0, 8'h30, 32'h0, FILL[0], 1'b0);
        send_ok(1'b0, 8'h31, 32'h0, FILL[1], 1'b0);
        send_ok(1'b0, 8'h32, 32'h0, FILL[2], 1'b0);
        check("rst_one_issued", en_cycles.size() - base, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {en_m, rsp_valid_m, cmd_ready_m}, 3'b000);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = en_cycles.size();
        repeat (20) @(negedge clk);
        check("rst_no_issue", en_cycles.size() - base, 0);
        check("rst_fifo_empty", cmd_ready_m, 1'b1);
        @(posedge clk);
        #1;

`ifdef MC_REQ_MASTER_STATS_EN
        send_ok(1'b1, 8'h40, 32'h1, 32'h0, 1'b0);
        send_ok(1'b1, 8'h41, 32'h2, 32'h0, 1'b0);
        send_ok(1'b1, 8'h42, 32'h3, 32'h0, 1'b0);
        send_ok(1'b0, 8'h40, 32'h0, 32'h1, 1'b0);
        send_ok(1'b0, 8'hFF, 32'h0, 32'h5A5A5A5A, 1'b1);
        drain("stats_drain");
        check("stat_wr", stat_wr_a, 16'd3);
        check("stat_rd", stat_rd_a, 16'd2);
        check("stat_err", stat_err_a, 16'd1);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        check("stat_clr_all", {stat_wr_a, stat_rd_a, stat_err_a}, '0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_req_master.md
Name: mc_req_master

Overview:
- Initiator end of the memory-controller slave interface (en / w_r / wr_addr / in_data out; data_out / slv_error in).
- Accepts read/write commands from an upstream agent over a valid/ready port and buffers them in a small command FIFO.
- Issues each command to the memory controller as a single en pulse, then captures data_out/slv_error after a fixed latency.
- Returns one response per command over a valid/ready port. Exactly one transaction is outstanding at the slave at any time.

Parameters:
- DATA_WIDTH, 32, data bus width (in_data, data_out, cmd_wdata, rsp_rdata)
- ADDR_WIDTH, 8, address width (wr_addr, cmd_addr)
- RD_LATENCY, 1, cycles from the en cycle to the cycle in which data_out/slv_error are valid; legal range 1..15
- CMD_DEPTH, 4, command FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  FIFO not full
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  command address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  upstream accepts response
- rsp_wr  out  1  echo of command type
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  captured slv_error
- en  out  1  slave enable, one-cycle pulse per transaction
- w_r  out  1  1=write, 0=read
- wr_addr  out  ADDR_WIDTH  slave address
- in_data  out  DATA_WIDTH  slave write data
- data_out  in  DATA_WIDTH  slave read data
- slv_error  in  1  slave error flag

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; cmd_ready=0 while reset is asserted, then 1 on the first cycle after deassertion.
  - FIFO emptied, FSM to IDLE, in-flight transaction dropped with no response.
- All outputs are registered.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = !full, computed from registered count only; no bypass. Push when full is ignored.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if FIFO not empty, pop head into the transaction register and go to ISSUE. A command pushed in cycle N is issued no earlier than cycle N+2.
  - ISSUE: en=1, w_r/wr_addr/in_data = transaction fields for exactly this one cycle (cycle T); load wait counter with RD_LATENCY; go to WAIT.
  - WAIT: decrement counter each cycle. At the clock edge ending cycle T+RD_LATENCY, capture data_out (reads only; writes capture 0) and slv_error; go to RESP.
  - RESP: rsp_valid=1; rsp_wr/rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready; then rsp_valid=0 and go to IDLE.
- Outside ISSUE: en=0, w_r=0, wr_addr=0, in_data=0.
- Peak throughput is one transaction per RD_LATENCY+3 cycles with rsp_ready held 1.
- rsp_ready low stalls the FSM; the FIFO keeps accepting until full.
- slv_error is sampled only in the capture cycle and ignored otherwise.

Optional Feature:
- Macro MC_REQ_MASTER_STATS_EN.
- Defined:
  - Adds outputs stat_wr_cnt[15:0], stat_rd_cnt[15:0], stat_err_cnt[15:0], all reset to 0.
  - Counters increment on response handshake by type; err increments when rsp_err=1.
  - Counters saturate at 16'hFFFF.
  - Input stat_clr (1 bit) synchronously zeroes all three; clear wins over increment in the same cycle.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mc_pkg:
  - DATA_WIDTH / ADDR_WIDTH defaults.
  - FSM state enum mc_mst_state_e {IDLE, ISSUE, WAIT, RESP}.
  - Packed struct mc_cmd_t {wr, addr, wdata}.
  - Constants W_R_WRITE=1, W_R_READ=0.
- One sub-module: mc_cmd_fifo, a parameterised synchronous FIFO of mc_cmd_t with push/pop/full/empty/count.

Test Plan:
- Write then read, RD_LATENCY=1:
  - Stimulus: cmd wr addr 8'h10 data 32'hDEADBEEF, then rd 8'h10; slave model returns DEADBEEF.
  - Required: one en pulse each, w_r=1 then 0; responses (wr=1, rdata=0, err=0) then (wr=0, rdata=DEADBEEF, err=0), in order.
- Latency sweep:
  - Stimulus: RD_LATENCY=3; slave drives data_out=32'h1234 only in cycle T+3, garbage elsewhere.
  - Required: rsp_rdata=32'h1234.
- FIFO full:
  - Stimulus: CMD_DEPTH=4, rsp_ready=0, push 6 back-to-back reads.
  - Required: cmd_ready drops after 5 accepted (4 in FIFO plus 1 in FSM); no extra en pulse until rsp_ready=1; all 5 responses delivered in order.
- Slave error:
  - Stimulus: slv_error=1 in the capture cycle of a read to 8'hFF.
  - Required: rsp_err=1; the next transaction has rsp_err=0.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT with 2 commands queued.
  - Required: en=0 and rsp_valid=0 immediately (asynchronous); no responses after release; FIFO empty.
- Stats (MC_REQ_MASTER_STATS_EN):
  - Stimulus: 3 writes, 2 reads (1 with error), then stat_clr.
  - Required: counts 3/2/1, then 0/0/0.
